// File: rtl/regfile_pkg.sv
// Shared types for the register file: geometry, address/data types and the
// one-entry pending-load buffer record.
package regfile_pkg;

   localparam int NREGS = 8;
   localparam int DW    = 8;
   localparam int AW    = $clog2(NREGS);

   typedef logic [AW-1:0] reg_addr_t;
   typedef logic [DW-1:0] reg_data_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t addr;
      reg_data_t data;
   } pend_entry_t;

endpackage : regfile_pkg

// File: rtl/regfile_wr_arb.sv
// Write arbiter for reg_file. Picks the single write that commits this cycle
// (ALU result, then pending load, then a fresh load) and computes the next
// pending-buffer contents, including the drops caused by younger ALU writes.
module regfile_wr_arb
   import regfile_pkg::*;
(
   input  logic          alu_we_i,
   input  logic [AW-1:0] alu_waddr_i,
   input  logic [DW-1:0] alu_wdata_i,
   input  logic          ld_we_i,
   input  logic [AW-1:0] ld_waddr_i,
   input  logic [DW-1:0] ld_wdata_i,
   input  pend_entry_t   pend_q_i,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [DW-1:0] wr_data_o,
   output pend_entry_t   pend_d_o
);

   logic ld_accept;

   // A load is only accepted while the pending buffer is empty.
   assign ld_accept = ld_we_i & ~pend_q_i.valid;

   // Select the committing write and the next pending entry.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned; otherwise synthesis infers a latch to hold it.
      wr_en_o   = 1'b0;
      wr_addr_o = '0;
      wr_data_o = '0;
      pend_d_o  = pend_q_i;

      if (alu_we_i) begin
         wr_en_o   = 1'b1;
         wr_addr_o = alu_waddr_i;
         wr_data_o = alu_wdata_i;
         if (pend_q_i.valid && (pend_q_i.addr == alu_waddr_i)) begin
            // The ALU result is younger than the deferred load: discard it.
            pend_d_o.valid = 1'b0;
         end else if (ld_accept && (ld_waddr_i != alu_waddr_i)) begin
            // Port busy with the ALU: defer the load by one entry.
            pend_d_o = '{valid: 1'b1, addr: ld_waddr_i, data: ld_wdata_i};
         end
         // A same-address accepted load is simply dropped.
      end else if (pend_q_i.valid) begin
         wr_en_o        = 1'b1;
         wr_addr_o      = pend_q_i.addr;
         wr_data_o      = pend_q_i.data;
         pend_d_o.valid = 1'b0;
      end else if (ld_accept) begin
         wr_en_o   = 1'b1;
         wr_addr_o = ld_waddr_i;
         wr_data_o = ld_wdata_i;
      end
   end

endmodule : regfile_wr_arb

// File: rtl/reg_file.sv
// 8x8-bit register file feeding the ALU operands, with an ALU write-back
// port, a load write port backed by a one-entry pending buffer, and the
// architectural zero flag. Define REGFILE_BYPASS_EN to forward the write
// committing this cycle to the read ports.
module reg_file
   import regfile_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   output logic [DW-1:0] rs_data,
   output logic [DW-1:0] rt_data,
   input  logic          alu_we,
   input  logic [AW-1:0] alu_waddr,
   input  logic [DW-1:0] alu_wdata,
   input  logic          flag_we,
   input  logic          zero_in,
   output logic          zero_flag,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_waddr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_ready,
   output logic          pend_valid
);

   reg_data_t   mem_q [NREGS];
   logic        flag_q;
   pend_entry_t pend_q;
   pend_entry_t pend_d;

   logic        wr_en;
   reg_addr_t   wr_addr;
   reg_data_t   wr_data;

   regfile_wr_arb u_wr_arb (
      .alu_we_i    (alu_we),
      .alu_waddr_i (alu_waddr),
      .alu_wdata_i (alu_wdata),
      .ld_we_i     (ld_we),
      .ld_waddr_i  (ld_waddr),
      .ld_wdata_i  (ld_wdata),
      .pend_q_i    (pend_q),
      .wr_en_o     (wr_en),
      .wr_addr_o   (wr_addr),
      .wr_data_o   (wr_data),
      .pend_d_o    (pend_d)
   );

   // Register array: cleared on reset, one write per cycle from the arbiter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the array is reset because software relies on every register
         // reading 0 after reset; a RAM macro without reset would not fit here.
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         // NOTE: non-blocking assignment so every flop samples pre-edge values.
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Pending-load buffer; an async reset loses any deferred load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // Zero flag: captured only on flag_we, independent of register writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_q <= 1'b0;
      end else if (flag_we) begin
         flag_q <= zero_in;
      end
   end

   // Read muxes, optionally forwarding the write committing this cycle.
   always_comb begin
      rs_data = mem_q[rs_addr];
      rt_data = mem_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == rs_addr)) rs_data = wr_data;
      if (wr_en && (wr_addr == rt_addr)) rt_data = wr_data;
`endif
   end

   assign zero_flag  = flag_q;
   assign pend_valid = pend_q.valid;
   assign ld_ready   = ~pend_q.valid;

   // A load presented while the buffer is full is a protocol violation.
   ld_protocol_a : assert property (@(posedge clk) disable iff (reset)
                                    !(ld_we && pend_q.valid));

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default or REGFILE_BYPASS_EN).
module tb_reg_file;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] rs_addr, rt_addr;
   logic [7:0] rs_data, rt_data;
   logic       alu_we;
   logic [2:0] alu_waddr;
   logic [7:0] alu_wdata;
   logic       flag_we, zero_in, zero_flag;
   logic       ld_we;
   logic [2:0] ld_waddr;
   logic [7:0] ld_wdata;
   logic       ld_ready, pend_valid;

   int vectors     = 0;
   int miscompares = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   reg_file dut (
      .clk        (clk),
      .reset      (reset),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .alu_we     (alu_we),
      .alu_waddr  (alu_waddr),
      .alu_wdata  (alu_wdata),
      .flag_we    (flag_we),
      .zero_in    (zero_in),
      .zero_flag  (zero_flag),
      .ld_we      (ld_we),
      .ld_waddr   (ld_waddr),
      .ld_wdata   (ld_wdata),
      .ld_ready   (ld_ready),
      .pend_valid (pend_valid)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait for the next rising edge, then settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_we  = 1'b0;
      ld_we   = 1'b0;
      flag_we = 1'b0;
   endtask

   // Read one address on both ports and check it.
   task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
      rs_addr = a;
      rt_addr = a;
      #1;
      check({tag, "_rs"}, rs_data, exp);
      check({tag, "_rt"}, rt_data, exp);
   endtask

   initial begin
      reset = 1'b1;
      rs_addr = '0; rt_addr = '0;
      alu_we = 0; alu_waddr = '0; alu_wdata = '0;
      flag_we = 0; zero_in = 0;
      ld_we = 0; ld_waddr = '0; ld_wdata = '0;
      #12;
      reset = 1'b0;
      tick();

      // 1. Reset state: both ports on different addresses each step
      for (int i = 0; i < 4; i++) begin
         rs_addr = 3'(i);
         rt_addr = 3'(i + 4);
         #1;
         check($sformatf("rst_r%0d", i), rs_data, 8'h00);
         check($sformatf("rst_r%0d", i + 4), rt_data, 8'h00);
      end
      check("rst_zero_flag", {7'd0, zero_flag}, 8'd0);
      check("rst_ld_ready", {7'd0, ld_ready}, 8'd1);
      check("rst_pend_valid", {7'd0, pend_valid}, 8'd0);

      // 2. ALU write r3 <- 5A; same-cycle visibility depends on bypass
      tick();
      alu_we = 1; alu_waddr = 3'd3; alu_wdata = 8'h5A;
      rs_addr = 3'd3; rt_addr = 3'd3;
      #1;
      check("alu_same_cycle", rs_data, BYP ? 8'h5A : 8'h00);
      tick();
      idle();
      rd("alu_r3", 3'd3, 8'h5A);

      // 3. Collision on different addresses: load deferred, then retired
      tick();
      alu_we = 1; alu_waddr = 3'd2; alu_wdata = 8'h11;
      ld_we  = 1; ld_waddr  = 3'd5; ld_wdata  = 8'h22;
      #1;
      check("col_ld_ready_pre", {7'd0, ld_ready}, 8'd1);
      tick();
      idle();
      rs_addr = 3'd2; rt_addr = 3'd5;
      #1;
      check("col_r2", rs_data, 8'h11);
      check("col_r5_retiring", rt_data, BYP ? 8'h22 : 8'h00);
      check("col_pend_valid", {7'd0, pend_valid}, 8'd1);
      check("col_ld_ready", {7'd0, ld_ready}, 8'd0);
      tick();
      check("ret_pend_valid", {7'd0, pend_valid}, 8'd0);
      check("ret_ld_ready", {7'd0, ld_ready}, 8'd1);
      rd("ret_r5", 3'd5, 8'h22);

      // Direct load with no ALU traffic: zero latency
      tick();
      ld_we = 1; ld_waddr = 3'd0; ld_wdata = 8'hC3;
      tick();
      idle();
      check("ld_direct_pend", {7'd0, pend_valid}, 8'd0);
      rd("ld_direct_r0", 3'd0, 8'hC3);

      // 4a. Same-address collision: load dropped
      tick();
      alu_we = 1; alu_waddr = 3'd4; alu_wdata = 8'hAA;
      ld_we  = 1; ld_waddr  = 3'd4; ld_wdata  = 8'hBB;
      tick();
      idle();
      check("same_pend_valid", {7'd0, pend_valid}, 8'd0);
      rd("same_r4", 3'd4, 8'hAA);
      tick();
      rd("same_r4_later", 3'd4, 8'hAA);

      // 4b. Pending r6 survives an ALU write elsewhere, then is discarded
      tick();
      alu_we = 1; alu_waddr = 3'd1; alu_wdata = 8'h33;
      ld_we  = 1; ld_waddr  = 3'd6; ld_wdata  = 8'h66;
      tick();
      ld_we = 0;
      alu_waddr = 3'd2; alu_wdata = 8'h44;
      check("hold_pend_set", {7'd0, pend_valid}, 8'd1);
      tick();
      check("hold_pend_kept", {7'd0, pend_valid}, 8'd1);
      alu_waddr = 3'd6; alu_wdata = 8'h01;
      tick();
      idle();
      check("drop_pend_valid", {7'd0, pend_valid}, 8'd0);
      rd("drop_r6", 3'd6, 8'h01);
      rd("drop_r1", 3'd1, 8'h33);
      rd("drop_r2", 3'd2, 8'h44);
      tick();
      rd("drop_r6_later", 3'd6, 8'h01);

      // 5. Zero flag capture and hold, independent of alu_we
      tick();
      flag_we = 1; zero_in = 1;
      tick();
      flag_we = 0; zero_in = 0;
      check("flag_set", {7'd0, zero_flag}, 8'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("flag_hold%0d", i), {7'd0, zero_flag}, 8'd1);
      end
      flag_we = 1; zero_in = 0; alu_we = 1; alu_waddr = 3'd5; alu_wdata = 8'h5E;
      tick();
      idle();
      check("flag_clear", {7'd0, zero_flag}, 8'd0);
      rd("flag_alu_r5", 3'd5, 8'h5E);

      // 6. Reset mid-operation loses the pending load
      tick();
      alu_we = 1; alu_waddr = 3'd0; alu_wdata = 8'h10;
      ld_we  = 1; ld_waddr  = 3'd7; ld_wdata  = 8'h77;
      tick();
      idle();
      check("mid_pend_set", {7'd0, pend_valid}, 8'd1);
      reset = 1'b1;
      #1;
      check("mid_pend_cleared", {7'd0, pend_valid}, 8'd0);
      check("mid_ld_ready", {7'd0, ld_ready}, 8'd1);
      rd("mid_r7", 3'd7, 8'h00);
      rd("mid_r0", 3'd0, 8'h00);
      tick();
      reset = 1'b0;
      tick();
      tick();
      rd("post_r7", 3'd7, 8'h00);
      check("post_pend_valid", {7'd0, pend_valid}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_reg_file
